edge_pulser_bank: RTL and testbench
===================================

Name: edge_pulser_bank

Overview:
- N-channel successor to the single-channel pulser: per channel it synchronises an asynchronous input, debounces it, and emits one-cycle pulses on a selectable edge (rising, falling or both).
- Optional hold-to-repeat auto-pulse for held inputs.
- Sits between board buttons/switches and the game control FSMs, replacing per-button pulser instances.

Parameters:
N, 4, number of independent channels
SYNC_STAGES, 2, synchroniser flops per channel (minimum 2)
DB_CYCLES, 4, consecutive differing samples needed to accept a new level (minimum 1)
EDGE_MODE, 0, 0 = rising, 1 = falling, 2 = both, 3 = treated as rising
REPEAT_DELAY, 0, cycles from initial rising pulse to first repeat pulse; 0 disables repeat
REPEAT_PERIOD, 8, cycles between subsequent repeat pulses (minimum 1)

Ports:
clk     in   1  system clock, single clock domain
rst     in   1  asynchronous, active-high reset
I       in   N  raw asynchronous channel inputs
en      in   N  per-channel pulse enable; debounce keeps running when low
Y       out  N  one-cycle pulse per detected edge or repeat
level   out  N  debounced level per channel
rep     out  N  high together with Y when the pulse is a repeat pulse

Behaviour:
- rst (async, active-high): clears all synchroniser flops, debounce counters, debounced levels, repeat counters, Y, level and rep to 0.
- Synchroniser: SYNC_STAGES-deep flop chain per channel; s = last stage.
- Debounce:
  - cnt increments each cycle that s != level; cleared on any cycle where s == level.
  - level takes the value of s on the edge where s has differed for DB_CYCLES consecutive cycles; cnt clears on that edge.
  - A glitch shorter than DB_CYCLES post-sync cycles never changes level.
- Edge detect:
  - Y is registered, so Y[k] is high for exactly the one cycle following a change of level[k] that matches EDGE_MODE, gated by en[k] sampled on that same edge.
  - Latency: a clean input change is seen on Y starting after the (SYNC_STAGES + DB_CYCLES + 1)th rising clk edge after the change; defaults give 7.
- Repeat (REPEAT_DELAY > 0 and EDGE_MODE != 1 only):
  - A per-channel counter starts at the rising-edge pulse.
  - While level stays 1: a repeat pulse fires REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles; Y and rep are both high for that one cycle.
  - level falling clears the counter immediately; in mode 2 the falling pulse is still generated (rep = 0).
  - en low masks repeat pulses but the counter keeps running, so cadence is preserved.
- Channels are fully independent; simultaneous edges on several channels produce simultaneous pulses.
- Counter widths: cnt is clog2(DB_CYCLES+1) bits; the repeat counter is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) bits. Neither counter wraps: both saturate or reload explicitly.
- Reset mid-operation: outputs drop to 0 asynchronously; no pulse is emitted for the reset itself.
- Post-reset high input: if I is held high through reset release, level rises after the normal latency and a rising pulse is generated.
- A pulse in progress during rst is cut off.

Decomposition:
- Shared package: EDGE_RISE/EDGE_FALL/EDGE_BOTH mode constants and a clog2 helper function.
- Sub-module: edge_pulser_chan, one channel (synchroniser, debounce, edge, repeat), instantiated N times in a generate loop.
- The top level holds only the generate loop and port slicing.

Test Plan:
- Defaults, I[0] 0→1 held 20 cycles, en = all 1 → Y[0] high in the single cycle after edge 7 only; level[0] = 1 from edge 6; other channels stay 0.
- I[1] high for 3 post-sync cycles, then low → level[1] and Y[1] stay 0; a 4-cycle pulse → level[1] rises, one Y[1] pulse.
- EDGE_MODE=2, I[2] 0→1→0 with 20 cycles between → exactly two Y[2] pulses, rep = 0 both times.
- REPEAT_DELAY=10, REPEAT_PERIOD=4, I[3] held 30 cycles post-debounce → pulses at offsets 0, 10, 14, 18, 22, 26 relative to the initial pulse; rep high on all but the first; release → no further pulses.
- en[0]=0 during an I[0] rising edge, then en[0]=1 → no pulse, level[0] = 1; the next falling edge produces no pulse in mode 0.
- Assert rst for 1 cycle mid-debounce with I held high → all outputs 0 immediately; after release, a rising pulse arrives 7 edges later.

Source files
------------

// File: rtl/edge_pulser_bank_pkg.sv
// Shared definitions for the edge pulser bank.
// Holds the edge-mode codes and the constant helper functions
// used to size the per-channel counters.
package edge_pulser_bank_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Ceiling log2 for sizing counters; returns the bits needed
  // to represent values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_pulser_chan.sv
// One channel of the edge pulser bank: synchroniser, debounce,
// edge detect and optional hold-to-repeat.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   i     - raw asynchronous input
//   en    - pulse enable (debounce and repeat cadence run regardless)
//   y     - one-cycle pulse per selected edge or repeat
//   level - debounced level
//   rep   - high with y when the pulse is a repeat
module edge_pulser_chan
  import edge_pulser_bank_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  input  logic en,
  output logic y,
  output logic level,
  output logic rep
);

  localparam int CW   = clog2(DB_CYCLES + 1);
  localparam int RMAX = imax(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = clog2(RMAX + 1);

  // Mode 3 falls through to rising-only behaviour.
  localparam bit RISE_ON = (EDGE_MODE != EDGE_FALL);
  localparam bit FALL_ON = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);
  localparam bit REP_ON  = (REPEAT_DELAY > 0) && (EDGE_MODE != EDGE_FALL);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_MAX    = RW'(RMAX);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   level_d_reg;
  logic                   rep_active_reg;
  logic                   rep_first_reg;
  logic [RW-1:0]          rcnt_reg;

  logic s;
  logic rise;
  logic fall;
  logic rep_hit;

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = level & ~level_d_reg;
  assign fall = ~level & level_d_reg;

  // The first repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
  assign rep_hit = REP_ON && rep_active_reg && level &&
                   (rcnt_reg == (rep_first_reg ? R_DELAY : R_PERIOD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i};
    end
  end

  // Debounce: accept s only after it has differed for DB_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      level   <= 1'b0;
    end else if (s != level) begin
      if (cnt_reg == CNT_LAST) begin
        level   <= s;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  // Repeat counter counts cycles since the last pulse of the held level.
  // It runs independently of en so masking does not disturb cadence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_active_reg <= 1'b0;
      rep_first_reg  <= 1'b0;
      rcnt_reg       <= '0;
    end else if (!REP_ON || !level) begin
      rep_active_reg <= 1'b0;
      rep_first_reg  <= 1'b0;
      rcnt_reg       <= '0;
    end else if (rise) begin
      rep_active_reg <= 1'b1;
      rep_first_reg  <= 1'b1;
      rcnt_reg       <= RW'(1);
    end else if (rep_active_reg) begin
      if (rep_hit) begin
        rep_first_reg <= 1'b0;
        rcnt_reg      <= RW'(1);
      end else if (rcnt_reg != R_MAX) begin
        rcnt_reg <= rcnt_reg + 1'b1;
      end
    end
  end

  // Outputs are registered one cycle after the level change is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d_reg <= 1'b0;
      y           <= 1'b0;
      rep         <= 1'b0;
    end else begin
      level_d_reg <= level;
      y           <= en & ((RISE_ON & rise) | (FALL_ON & fall) | rep_hit);
      rep         <= en & rep_hit;
    end
  end

endmodule

// File: rtl/edge_pulser_bank.sv
// N-channel edge pulser: each channel synchronises, debounces and
// edge-detects its own input, with optional hold-to-repeat.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   I     - raw asynchronous inputs, one per channel
//   en    - per-channel pulse enable
//   Y     - per-channel one-cycle pulses
//   level - per-channel debounced level
//   rep   - per-channel repeat flag, high together with Y
module edge_pulser_bank
  import edge_pulser_bank_pkg::*;
#(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int EDGE_MODE     = EDGE_RISE,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] I,
  input  logic [N-1:0] en,
  output logic [N-1:0] Y,
  output logic [N-1:0] level,
  output logic [N-1:0] rep
);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    edge_pulser_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .EDGE_MODE    (EDGE_MODE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .i    (I[gi]),
      .en   (en[gi]),
      .y    (Y[gi]),
      .level(level[gi]),
      .rep  (rep[gi])
    );
  end

endmodule

// File: tb/tb_edge_pulser_bank.sv
// Directed bench for edge_pulser_bank: three instances (rising,
// both-edge, rising with repeat) share clock, reset and inputs.
module tb_edge_pulser_bank;

  logic       clk;
  logic       rst;
  logic [3:0] I;
  logic [3:0] en;
  logic [3:0] y0, lv0, rp0;
  logic [3:0] yb, lvb, rpb;
  logic [3:0] yr, lvr, rpr;

  int checks;
  int failures;

  edge_pulser_bank dut0 (
    .clk(clk), .rst(rst), .I(I), .en(en), .Y(y0), .level(lv0), .rep(rp0)
  );

  edge_pulser_bank #(.EDGE_MODE(2)) dut_both (
    .clk(clk), .rst(rst), .I(I), .en(en), .Y(yb), .level(lvb), .rep(rpb)
  );

  edge_pulser_bank #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_rep (
    .clk(clk), .rst(rst), .I(I), .en(en), .Y(yr), .level(lvr), .rep(rpr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("check %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic hit;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    I   = 4'b0000;
    en  = 4'b1111;

    // Reset state
    tick();
    tick();
    chk("rst_y0", y0, 4'b0000);
    chk("rst_lv0", lv0, 4'b0000);
    chk("rst_rp0", rp0, 4'b0000);
    chk("rst_yb", yb, 4'b0000);
    chk("rst_yr", yr, 4'b0000);
    chk("rst_rpr", rpr, 4'b0000);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_lv0", lv0, 4'b0000);
    $display("step reset: done");

    // A: ch0 and ch2 rise and hold 20 cycles
    I = 4'b0101;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("A_lv0", lv0, (k >= 6) ? 4'b0101 : 4'b0000);
      chk("A_y0", y0, (k == 7) ? 4'b0101 : 4'b0000);
      chk("A_rp0", rp0, 4'b0000);
      chk("A_yb", yb, (k == 7) ? 4'b0101 : 4'b0000);
      chk("A_yr", yr, (k == 7 || k == 17) ? 4'b0101 : 4'b0000);
      chk("A_rpr", rpr, (k == 17) ? 4'b0101 : 4'b0000);
    end
    $display("step A: rise + hold done");

    // B: release; mode 2 gives a falling pulse, repeat stops once level drops
    I = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("B_lv0", lv0, (k >= 6) ? 4'b0000 : 4'b0101);
      chk("B_y0", y0, 4'b0000);
      chk("B_yb", yb, (k == 7) ? 4'b0101 : 4'b0000);
      chk("B_rpb", rpb, 4'b0000);
      chk("B_yr", yr, (k == 1 || k == 5) ? 4'b0101 : 4'b0000);
      chk("B_rpr", rpr, (k == 1 || k == 5) ? 4'b0101 : 4'b0000);
    end
    $display("step B: release done");

    // C: ch3 held; repeats at offsets 0,10,14,18,22,26 from the first pulse
    I = 4'b1000;
    for (int k = 1; k <= 36; k++) begin
      tick();
      hit = (k == 7) || (k >= 17 && ((k - 17) % 4) == 0);
      chk("C_lvr", lvr, (k >= 6) ? 4'b1000 : 4'b0000);
      chk("C_yr", yr, hit ? 4'b1000 : 4'b0000);
      chk("C_rpr", rpr, (hit && k != 7) ? 4'b1000 : 4'b0000);
      chk("C_y0", y0, (k == 7) ? 4'b1000 : 4'b0000);
    end
    I = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("C2_lvr", lvr, (k >= 6) ? 4'b0000 : 4'b1000);
      chk("C2_yr", yr, (k == 1 || k == 5) ? 4'b1000 : 4'b0000);
      chk("C2_rpr", rpr, (k == 1 || k == 5) ? 4'b1000 : 4'b0000);
    end
    $display("step C: repeat cadence done");

    // D: 3-cycle glitch on ch1 is rejected, a 4-cycle pulse is accepted
    I = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("D_glitch_lv0", lv0, 4'b0000);
      chk("D_glitch_y0", y0, 4'b0000);
      if (k == 3) I = 4'b0000;
    end
    I = 4'b0010;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("D_pulse_lv0", lv0, (k >= 6 && k < 10) ? 4'b0010 : 4'b0000);
      chk("D_pulse_y0", y0, (k == 7) ? 4'b0010 : 4'b0000);
      if (k == 4) I = 4'b0000;
    end
    $display("step D: debounce done");

    // E: en[0] low masks the rising pulse; falling edge gives none in mode 0
    en = 4'b1110;
    I  = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("E_lv0", lv0, (k >= 6) ? 4'b0001 : 4'b0000);
      chk("E_y0", y0, 4'b0000);
      chk("E_yb", yb, 4'b0000);
    end
    en = 4'b1111;
    I  = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("E2_lv0", lv0, (k >= 6) ? 4'b0000 : 4'b0001);
      chk("E2_y0", y0, 4'b0000);
    end
    $display("step E: enable masking done");

    // F: reset mid-debounce while ch2 level is high
    I = 4'b0100;
    for (int k = 1; k <= 8; k++) tick();
    chk("F_pre_lv0", lv0, 4'b0100);
    I = 4'b0101;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("F_rst_lv0", lv0, 4'b0000);
    chk("F_rst_y0", y0, 4'b0000);
    chk("F_rst_lvr", lvr, 4'b0000);
    chk("F_rst_yb", yb, 4'b0000);
    tick();
    chk("F_hold_lv0", lv0, 4'b0000);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("F_lv0", lv0, (k >= 6) ? 4'b0101 : 4'b0000);
      chk("F_y0", y0, (k == 7) ? 4'b0101 : 4'b0000);
      chk("F_rp0", rp0, 4'b0000);
    end
    $display("step F: reset recovery done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
